// File: rtl/pb_event_ctrl.sv
// Multi-channel push-button front end.
// Each channel synchronizes its raw pin and debounces press and release.
// It then holds a debounced level and raises single-cycle press, release,
// long-press and auto-repeat events. Channels share no state.
module pb_event_ctrl #(
    parameter int NUM_PB        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 16,
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 250000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_PB-1:0] PB,
    output logic [NUM_PB-1:0] pressed,
    output logic [NUM_PB-1:0] press_pulse,
    output logic [NUM_PB-1:0] release_pulse,
    output logic [NUM_PB-1:0] long_pulse,
    output logic [NUM_PB-1:0] repeat_pulse
);

    // Pin level while the button is released; also the synchronizer reset value.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    localparam int DB_W     = $clog2(DB_CYCLES);
    localparam int HOLD_MAX = LONG_CYCLES + REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] LONG_PRE  = HOLD_W'(LONG_CYCLES - 1);
    // After a repeat at HOLD_MAX the count restarts just past LONG_CYCLES.
    // The next HOLD_MAX is then exactly REPEAT_CYCLES edges later.
    localparam logic [HOLD_W-1:0] WRAP_V    = HOLD_W'(LONG_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHK_DN = 2'd1,
        S_HELD   = 2'd2,
        S_CHK_UP = 2'd3
    } pb_state_t;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   act;
        pb_state_t              state_q, state_d;
        logic [DB_W-1:0]        db_q, db_d;
        logic [HOLD_W-1:0]      hold_q, hold_d, hold_inc;
        logic                   pressed_q, press_q, release_q, long_q, repeat_q;
        logic                   pressed_d, press_d, release_d, long_d, repeat_d;

        // Shift the raw pin through the synchronizer chain; reset to idle level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{IDLE_LVL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], PB[i]};
            end
        end

        // act is 1 while the synchronized pin shows the pressed level.
        assign act = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;

        // Saturating or wrapping increment of the hold counter.
        always_comb begin
            hold_inc = hold_q;
            if (hold_q != HOLD_LAST) begin
                hold_inc = hold_q + HOLD_ONE;
            end else if (REPEAT_CYCLES > 0) begin
                hold_inc = WRAP_V;
            end else begin
                hold_inc = HOLD_LAST;
            end
        end

        // State register, counters and registered event outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= S_IDLE;
                db_q      <= '0;
                hold_q    <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_q      <= db_d;
                hold_q    <= hold_d;
                pressed_q <= pressed_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        // Next-state and counter logic of the debounce / hold FSM.
        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            hold_d  = hold_q;
            case (state_q)
                S_IDLE: begin
                    hold_d = '0;
                    if (act) begin
                        state_d = S_CHK_DN;
                        db_d    = DB_ONE;
                    end else begin
                        db_d = '0;
                    end
                end
                S_CHK_DN: begin
                    if (!act) begin
                        state_d = S_IDLE;
                        db_d    = '0;
                    end else if (db_q == DB_LAST) begin
                        state_d = S_HELD;
                        db_d    = '0;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + DB_ONE;
                    end
                end
                S_HELD: begin
                    hold_d = hold_inc;
                    if (!act) begin
                        state_d = S_CHK_UP;
                        db_d    = DB_ONE;
                    end
                end
                S_CHK_UP: begin
                    if (act) begin
                        state_d = S_HELD;
                        db_d    = '0;
                    end else if (db_q == DB_LAST) begin
                        state_d = S_IDLE;
                        db_d    = '0;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + DB_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    db_d    = '0;
                    hold_d  = '0;
                end
            endcase
        end

        // Event decode; the results are registered with the state.
        always_comb begin
            pressed_d = (state_d == S_HELD) || (state_d == S_CHK_UP);
            press_d   = (state_q == S_CHK_DN) && (state_d == S_HELD);
            release_d = (state_q == S_CHK_UP) && (state_d == S_IDLE);
            long_d    = (state_q == S_HELD) && (hold_q == LONG_PRE);
            repeat_d  = (REPEAT_CYCLES > 0) && (state_q == S_HELD) &&
                        (hold_inc == HOLD_LAST);
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
        assign repeat_pulse[i]  = repeat_q;
    end

endmodule
